// File: rtl/reg_in_sel_pipe.sv
// Register-file write-data select feeding a two-entry skid buffer.
// Define REG_IN_SEL_ERRCNT_EN to add the saturating err_cnt output.
module reg_in_sel_pipe #(
    parameter int WIDTH = 64,
    parameter int NCH   = 5,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] d_in,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef REG_IN_SEL_ERRCNT_EN
    output logic                 sel_err,
    output logic [7:0]           err_cnt
`else
    output logic                 sel_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic             accept;
    logic             pop;
    logic             sel_ok;
    logic [WIDTH-1:0] word;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;
    assign sel_ok = {1'b0, sel} < NCH_W;

    // Out-of-range selects replay the last legal word instead of latching.
    always_comb begin
        word = last_q;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                word = d_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        last_d    = last_q;
        sel_err_d = 1'b0;
        if (accept) begin
            if (sel_ok) begin
                last_d = word;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    h_d     = word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    h_d = word;
                end else if (accept) begin
                    s_d     = word;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    h_d     = s_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            h_q         <= '0;
            s_q         <= '0;
            last_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            s_q         <= s_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = h_q;
    assign sel_err   = sel_err_q;

`ifdef REG_IN_SEL_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sel_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_reg_in_sel_pipe.sv
// Bench for reg_in_sel_pipe: directed steps plus random traffic
// checked against a queue-based model of the select and buffer.
module tb_reg_in_sel_pipe;

    localparam int WIDTH = 64;
    localparam int NCH   = 5;
    localparam int SELW  = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH*WIDTH-1:0] d_in;
    logic [SELW-1:0]      sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;
    logic [7:0]           err_cnt;

    logic [WIDTH-1:0] ch [NCH];

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_last;
    logic             m_err;
    int               m_cnt;

    always #5 clk = ~clk;

    always_comb begin
        d_in = '0;
        for (int k = 0; k < NCH; k++) begin
            d_in[k*WIDTH +: WIDTH] = ch[k];
        end
    end

`ifndef REG_IN_SEL_ERRCNT_EN
    assign err_cnt = 8'd0;
`endif

    reg_in_sel_pipe #(
        .WIDTH(WIDTH),
        .NCH  (NCH),
        .SELW (SELW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_in     (d_in),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef REG_IN_SEL_ERRCNT_EN
        .sel_err  (sel_err),
        .err_cnt  (err_cnt)
`else
        .sel_err  (sel_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [SELW-1:0] s,
                        input logic ordy, input logic rst);
        logic acc;
        logic pp;
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_last = '0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            acc   = v && (mq.size() < 2);
            pp    = ordy && (mq.size() > 0);
            m_err = 1'b0;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                if (int'(s) < NCH) begin
                    m_last = ch[s];
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                mq.push_back(m_last);
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("sel_err", 64'(sel_err), 64'(m_err));
        if (mq.size() > 0) chk("out_data", out_data, mq[0]);
        if (rst) chk("rst_data", out_data, 64'h0);
`ifdef REG_IN_SEL_ERRCNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
    endtask

    initial begin
        m_last = '0;
        m_err  = 1'b0;
        m_cnt  = 0;
        for (int k = 0; k < NCH; k++) ch[k] = 64'h1000 + 64'(k);

        // reset, with a live offer that must be ignored
        step(1'b1, 3'd1, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // back-to-back accepts through every channel
        for (int k = 0; k < NCH; k++) step(1'b1, SELW'(k), 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // legal select then out-of-range repeats it
        ch[3] = 64'hAA;
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b0);
        chk("repeat_aa", out_data, 64'hAA);
        step(1'b0, 3'd7, 1'b1, 1'b0);

        // stall: two words fill H and S, third offer blocked
        ch[0] = 64'h11;
        step(1'b1, 3'd0, 1'b0, 1'b0);
        ch[0] = 64'h22;
        step(1'b1, 3'd0, 1'b0, 1'b0);
        ch[0] = 64'h99;
        step(1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b0, 3'd6, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // simultaneous accept and pop in ONE
        ch[1] = 64'h44;
        step(1'b1, 3'd1, 1'b1, 1'b0);
        ch[1] = 64'h33;
        step(1'b1, 3'd1, 1'b1, 1'b0);
        chk("no_bubble", out_data, 64'h33);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // reset while full; last clears so out-of-range yields 0
        step(1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b0, 1'b1);
        step(1'b1, 3'd5, 1'b1, 1'b0);
        chk("rst_last", out_data, 64'h0);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // long run of out-of-range accepts saturates the counter
        for (int i = 0; i < 300; i++) step(1'b1, 3'd6, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NCH; k++) ch[k] = {$urandom, $urandom};
            step($urandom_range(0, 3) != 0, SELW'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
